// File: rtl/kinematics_pkg.sv
// ----------------------------------------------------------------------------
// kinematics_pkg
// Shared definitions for the wheel/robot kinematics blocks.
//   - Default output word width and fraction width of the sign-magnitude
//     velocity words exchanged between wheel_velocity and local_velocity.
//   - Fraction width of the K_SCALE coefficient (Q15).
//   - FSM state encoding of the wheel_velocity scaling sequencer.
//   - sm_sign_bit(): position of the sign bit in a sign-magnitude word.
// ----------------------------------------------------------------------------
package kinematics_pkg;

  localparam int KIN_N_WIDTH = 32;  // velocity word width
  localparam int KIN_Q_WIDTH = 15;  // velocity word fraction bits
  localparam int KIN_K_FRAC  = 15;  // fraction bits of the K_SCALE coefficient

  typedef enum logic [1:0] {
    VEL_IDLE = 2'd0,
    VEL_MUL  = 2'd1,
    VEL_DONE = 2'd2
  } vel_state_t;

  // Sign-magnitude words carry the sign in their most significant bit.
  function automatic int sm_sign_bit(input int width);
    return width - 1;
  endfunction

endpackage

// File: rtl/wheel_velocity_quad_decoder.sv
// ----------------------------------------------------------------------------
// quad_decoder
// Synchronises the two asynchronous encoder channels through two flip-flops
// each, then x4-decodes the synchronised {A,B} pair against the previous one.
//   i_clk      clock
//   i_rst_n    synchronous active-low reset (synchronisers/previous -> 00)
//   i_enc_a    encoder channel A (asynchronous)
//   i_enc_b    encoder channel B (asynchronous)
//   o_delta    signed step for this cycle: +1, -1 or 0
//   o_err      sticky flag, set when both channels change in one cycle
// ----------------------------------------------------------------------------
module quad_decoder (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_enc_a,
  input  logic              i_enc_b,
  output logic signed [1:0] o_delta,
  output logic              o_err
);

  logic [1:0] r_sync1;
  logic [1:0] r_sync2;
  logic [1:0] r_prev;
  logic       r_err;

  logic [1:0] w_pos_prev;
  logic [1:0] w_pos_cur;
  logic [1:0] w_step;
  logic       w_illegal;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync1 <= 2'b00;
      r_sync2 <= 2'b00;
      r_prev  <= 2'b00;
      r_err   <= 1'b0;
    end else begin
      r_sync1 <= {i_enc_a, i_enc_b};
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_err   <= r_err | w_illegal;
    end
  end

  // Gray {A,B} 00,01,11,10 maps to positions 0,1,2,3 as {A, A^B}; the
  // modulo-4 position difference then tells the direction directly.
  assign w_pos_prev = {r_prev[1], r_prev[1] ^ r_prev[0]};
  assign w_pos_cur  = {r_sync2[1], r_sync2[1] ^ r_sync2[0]};
  assign w_step     = w_pos_cur - w_pos_prev;

  always_comb begin
    o_delta   = 2'sb00;
    w_illegal = 1'b0;
    case (w_step)
      2'd1:    o_delta   = 2'sb01;
      2'd3:    o_delta   = 2'sb11;
      2'd2:    w_illegal = 1'b1;   // both bits flipped: direction unknown
      default: o_delta   = 2'sb00;
    endcase
  end

  assign o_err = r_err;

endmodule

// File: rtl/wheel_velocity.sv
// ----------------------------------------------------------------------------
// wheel_velocity
// Measures wheel angular speed from a quadrature encoder. Steps are counted
// over a fixed window of SAMPLE_CYCLES clocks; at each window end the count
// is captured and scaled by K_SCALE (Q15 rad/s per count) with a serial
// shift-add multiplier, producing a sign-magnitude Q_WIDTH word.
//
// Ports
//   WHEEL_VELOCITY_CLOCK_50       50 MHz clock (sole clock)
//   WHEEL_VELOCITY_Reset_InLow    synchronous active-low reset
//   WHEEL_VELOCITY_EncA_In        encoder channel A (asynchronous)
//   WHEEL_VELOCITY_EncB_In        encoder channel B (asynchronous)
//   WHEEL_VELOCITY_W_OutBus       speed, sign-magnitude, MSB = sign
//   WHEEL_VELOCITY_Valid_OutHigh  one-cycle pulse when W_OutBus updates
//   WHEEL_VELOCITY_Err_OutHigh    sticky illegal-transition flag
//
// Build option
//   WHEEL_VELOCITY_FILTER_EN  when defined, the multiplied count is the
//                             floor average of this and the previous
//                             window's count.
// ----------------------------------------------------------------------------
module wheel_velocity
  import kinematics_pkg::*;
#(
  parameter int          N_WIDTH       = KIN_N_WIDTH,
  parameter int          Q_WIDTH       = KIN_Q_WIDTH,
  parameter int          COUNT_WIDTH   = 16,
  parameter int          SAMPLE_CYCLES = 500000,
  parameter logic [15:0] K_SCALE       = 16'd1024
) (
  input  logic               WHEEL_VELOCITY_CLOCK_50,
  input  logic               WHEEL_VELOCITY_Reset_InLow,
  input  logic               WHEEL_VELOCITY_EncA_In,
  input  logic               WHEEL_VELOCITY_EncB_In,
  output logic [N_WIDTH-1:0] WHEEL_VELOCITY_W_OutBus,
  output logic               WHEEL_VELOCITY_Valid_OutHigh,
  output logic               WHEEL_VELOCITY_Err_OutHigh
);

  localparam int MAG_W    = N_WIDTH - 1;
  localparam int SIGN_BIT = sm_sign_bit(N_WIDTH);
  localparam int WIN_W    = $clog2(SAMPLE_CYCLES);
  localparam int BIT_W    = $clog2(COUNT_WIDTH + 1);

  // Symmetric saturation limits, expressed one bit wider than the count.
  localparam logic signed [COUNT_WIDTH:0] SUM_MAX = {2'b00, {(COUNT_WIDTH-1){1'b1}}};
  localparam logic signed [COUNT_WIDTH:0] SUM_MIN = -SUM_MAX;

  logic clk;
  logic rst_n;
  assign clk   = WHEEL_VELOCITY_CLOCK_50;
  assign rst_n = WHEEL_VELOCITY_Reset_InLow;

  // ---------------- quadrature decode ----------------
  logic signed [1:0] w_delta;
  logic              w_err;

  quad_decoder u_quad_decoder (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_enc_a (WHEEL_VELOCITY_EncA_In),
    .i_enc_b (WHEEL_VELOCITY_EncB_In),
    .o_delta (w_delta),
    .o_err   (w_err)
  );

  // ---------------- window accumulation ----------------
  logic [WIN_W-1:0]              r_win;
  logic signed [COUNT_WIDTH-1:0] r_acc;
  logic signed [COUNT_WIDTH-1:0] r_count;
  logic                          r_start;

  logic                          w_win_end;
  logic signed [COUNT_WIDTH:0]   w_sum;
  logic signed [COUNT_WIDTH-1:0] w_sat;

  assign w_win_end = (r_win == WIN_W'(SAMPLE_CYCLES - 1));
  assign w_sum     = {r_acc[COUNT_WIDTH-1], r_acc}
                   + {{(COUNT_WIDTH-1){w_delta[1]}}, w_delta};

  always_comb begin
    w_sat = w_sum[COUNT_WIDTH-1:0];
    if (w_sum > SUM_MAX)      w_sat = SUM_MAX[COUNT_WIDTH-1:0];
    else if (w_sum < SUM_MIN) w_sat = SUM_MIN[COUNT_WIDTH-1:0];
  end

  // The window-end delta goes into the captured value, and the accumulator
  // restarts from zero, so no step is dropped or counted twice.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_win   <= '0;
      r_acc   <= '0;
      r_count <= '0;
      r_start <= 1'b0;
    end else begin
      r_start <= w_win_end;
      if (w_win_end) begin
        r_win   <= '0;
        r_acc   <= '0;
        r_count <= w_sat;
      end else begin
        r_win   <= r_win + WIN_W'(1);
        r_acc   <= w_sat;
      end
    end
  end

  // ---------------- optional count filter ----------------
  logic signed [COUNT_WIDTH-1:0] w_mul_count;

`ifdef WHEEL_VELOCITY_FILTER_EN
  logic signed [COUNT_WIDTH-1:0] r_prev_count;
  logic signed [COUNT_WIDTH:0]   w_pair;

  assign w_pair      = {r_count[COUNT_WIDTH-1], r_count}
                     + {r_prev_count[COUNT_WIDTH-1], r_prev_count};
  // Arithmetic shift of a two's-complement sum rounds toward -inf.
  assign w_mul_count = COUNT_WIDTH'(w_pair >>> 1);

  always_ff @(posedge clk) begin
    if (!rst_n)       r_prev_count <= '0;
    else if (r_start) r_prev_count <= r_count;
  end
`else
  assign w_mul_count = r_count;
`endif

  // ---------------- serial multiplier / sequencer ----------------
  vel_state_t               r_state;
  vel_state_t               w_state_next;
  logic [COUNT_WIDTH-1:0]   r_mplier;
  logic [MAG_W-1:0]         r_mcand;
  logic [MAG_W-1:0]         r_prod;
  logic [BIT_W-1:0]         r_bit;
  logic                     r_neg;
  logic [N_WIDTH-1:0]       r_w_out;

  logic [COUNT_WIDTH-1:0]   w_abs;
  logic [MAG_W-1:0]         w_prod_next;
  logic [MAG_W-1:0]         w_mag;
  logic                     w_last_bit;

  // The most-negative code never reaches here, so negation cannot overflow.
  assign w_abs       = w_mul_count[COUNT_WIDTH-1] ? COUNT_WIDTH'(-w_mul_count)
                                                  : COUNT_WIDTH'(w_mul_count);
  assign w_prod_next = r_prod + (r_mplier[0] ? r_mcand : '0);
  assign w_last_bit  = (r_bit == BIT_W'(COUNT_WIDTH - 1));

  // The product is integer x Q(KIN_K_FRAC); realign to Q_WIDTH fraction bits.
  generate
    if (Q_WIDTH >= KIN_K_FRAC) begin : g_q_up
      assign w_mag = w_prod_next << (Q_WIDTH - KIN_K_FRAC);
    end else begin : g_q_down
      assign w_mag = w_prod_next >> (KIN_K_FRAC - Q_WIDTH);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= VEL_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      VEL_IDLE: if (r_start) w_state_next = VEL_MUL;
      VEL_MUL:  if (w_last_bit) w_state_next = VEL_DONE;
      VEL_DONE: w_state_next = VEL_IDLE;
      default:  w_state_next = VEL_IDLE;
    endcase
  end

  // The output word is written on the MUL->DONE edge so that it is already
  // presented during the single DONE cycle that carries Valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mplier <= '0;
      r_mcand  <= '0;
      r_prod   <= '0;
      r_bit    <= '0;
      r_neg    <= 1'b0;
      r_w_out  <= '0;
    end else begin
      case (r_state)
        VEL_IDLE: begin
          if (r_start) begin
            r_mplier <= w_abs;
            r_mcand  <= MAG_W'(K_SCALE);
            r_prod   <= '0;
            r_bit    <= '0;
            r_neg    <= w_mul_count[COUNT_WIDTH-1];
          end
        end
        VEL_MUL: begin
          r_prod   <= w_prod_next;
          r_mplier <= r_mplier >> 1;
          r_mcand  <= r_mcand << 1;
          r_bit    <= r_bit + BIT_W'(1);
          if (w_last_bit) begin
            // A zero magnitude is always emitted as positive zero.
            r_w_out[SIGN_BIT]   <= r_neg && (w_mag != '0);
            r_w_out[MAG_W-1:0]  <= w_mag;
          end
        end
        default: ;
      endcase
    end
  end

  assign WHEEL_VELOCITY_W_OutBus      = r_w_out;
  assign WHEEL_VELOCITY_Valid_OutHigh = (r_state == VEL_DONE);
  assign WHEEL_VELOCITY_Err_OutHigh   = w_err;

endmodule

// File: tb/tb_wheel_velocity.sv
module tb_wheel_velocity;

  localparam int S = 1000;   // window length used by both instances

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        enc_a;
  logic        enc_b;
  logic [31:0] w0, w1;
  logic        v0, v1, e0, e1;

  // Full-width instance and a narrow-count instance that saturates readily.
  wheel_velocity #(
    .N_WIDTH(32), .Q_WIDTH(15), .COUNT_WIDTH(16),
    .SAMPLE_CYCLES(S), .K_SCALE(16'd1024)
  ) dut (
    .WHEEL_VELOCITY_CLOCK_50      (clk),
    .WHEEL_VELOCITY_Reset_InLow   (rst_n),
    .WHEEL_VELOCITY_EncA_In       (enc_a),
    .WHEEL_VELOCITY_EncB_In       (enc_b),
    .WHEEL_VELOCITY_W_OutBus      (w0),
    .WHEEL_VELOCITY_Valid_OutHigh (v0),
    .WHEEL_VELOCITY_Err_OutHigh   (e0)
  );

  wheel_velocity #(
    .N_WIDTH(32), .Q_WIDTH(15), .COUNT_WIDTH(8),
    .SAMPLE_CYCLES(S), .K_SCALE(16'd1024)
  ) dut_sat (
    .WHEEL_VELOCITY_CLOCK_50      (clk),
    .WHEEL_VELOCITY_Reset_InLow   (rst_n),
    .WHEEL_VELOCITY_EncA_In       (enc_a),
    .WHEEL_VELOCITY_EncB_In       (enc_b),
    .WHEEL_VELOCITY_W_OutBus      (w1),
    .WHEEL_VELOCITY_Valid_OutHigh (v1),
    .WHEEL_VELOCITY_Err_OutHigh   (e1)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;   // cycles since the last clock edge that saw reset
  int          pos      = 0;   // encoder position modulo 4
  int          acc [2][64];    // per-instance, per-window step totals
  logic [31:0] last_w [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int cw_of(input int d);
    return (d == 0) ? 16 : 8;
  endfunction

  function automatic logic [1:0] gray(input int p);
    logic [1:0] g;
    case (p)
      0:       g = 2'b00;
      1:       g = 2'b01;
      2:       g = 2'b11;
      default: g = 2'b10;
    endcase
    return g;
  endfunction

  // ---------------- reference model ----------------
  task automatic model_clear();
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < 64; w++) acc[d][w] = 0;
  endtask

  // A change driven during cycle k reaches the decoder two synchroniser
  // stages later, so it belongs to the window holding cycle k+2.
  task automatic model_apply(input int p_old, input int p_new, input int k);
    int diff, w, v, lim;
    diff = (p_new - p_old + 4) % 4;
    w    = (k + 2) / S;
    if (diff == 1)      v = 1;
    else if (diff == 3) v = -1;
    else                return;   // no change or illegal jump: no count
    if (w > 63) return;
    for (int d = 0; d < 2; d++) begin
      lim = (1 << (cw_of(d) - 1)) - 1;
      acc[d][w] = acc[d][w] + v;
      if (acc[d][w] > lim)  acc[d][w] = lim;
      if (acc[d][w] < -lim) acc[d][w] = -lim;
    end
  endtask

  function automatic logic [31:0] expected_word(input int d, input int idx);
    int c, mag;
    c = acc[d][idx];
`ifdef WHEEL_VELOCITY_FILTER_EN
    c = (c + ((idx > 0) ? acc[d][idx-1] : 0)) >>> 1;
`endif
    mag = ((c < 0) ? -c : c) * 1024;
    return (c < 0) ? (32'h8000_0000 | mag) : mag;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive_step(input int dir);
    int old;
    @(negedge clk);
    old = pos;
    pos = (pos + dir + 4) % 4;
    {enc_a, enc_b} = gray(pos);
    model_apply(old, pos, cyc);
  endtask

  task automatic run_steps(input int n, input int dir, input int gap_lo, input int gap_hi);
    int dd, gap;
    for (int i = 0; i < n; i++) begin
      dd  = (dir != 0) ? dir : (($urandom_range(0, 1) == 1) ? 1 : -1);
      gap = $urandom_range(gap_lo, gap_hi);
      drive_step(dd);
      repeat (gap - 1) @(negedge clk);
    end
  endtask

  task automatic wait_mod(input int m);
    do @(negedge clk); while ((cyc % S) != m);
  endtask

  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // ---------------- output monitor ----------------
  // Each window ends on cycle S-1 of that window; its result must appear
  // COUNT_WIDTH+2 cycles later and nowhere else.
  always @(negedge clk) begin
    int          first, idx;
    logic        vld, exp_v;
    logic [31:0] wo;
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        first = S - 1 + cw_of(d) + 2;
        vld   = (d == 0) ? v0 : v1;
        wo    = (d == 0) ? w0 : w1;
        exp_v = (cyc >= first) && (((cyc - first) % S) == 0);
        if (exp_v || vld)
          check_eq((d == 0) ? "valid16" : "valid8", {31'd0, vld}, {31'd0, exp_v});
        if (exp_v) begin
          idx = (cyc - first) / S;
          check_eq((d == 0) ? "word16" : "word8", wo, expected_word(d, idx));
          $display("window %0d inst%0d: W=0x%08h", idx, d, wo);
          last_w[d] = wo;
        end else if ((cyc + 1 >= first) && (((cyc + 1 - first) % S) == 0)) begin
          check_eq((d == 0) ? "hold16" : "hold8", wo, last_w[d]);
        end
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    rst_n = 1'b0;
    enc_a = 1'b0;
    enc_b = 1'b0;
    last_w[0] = '0;
    last_w[1] = '0;
    model_clear();
    repeat (3) @(negedge clk);
    check_eq("rst_w16",   w0, 32'h0);
    check_eq("rst_w8",    w1, 32'h0);
    check_eq("rst_valid", {30'd0, v1, v0}, 32'h0);
    check_eq("rst_err",   {30'd0, e1, e0}, 32'h0);
    rst_n = 1'b1;

    // Window 0: 100 forward steps, 8 clocks apart.
    wait_mod(1); run_steps(100, 1, 8, 8);
    // Window 1: 100 reverse steps.
    wait_mod(1); run_steps(100, -1, 8, 8);
    // Window 2: no edges.
    wait_mod(1);
    // Window 3: 250 forward steps, past the narrow instance's limit.
    wait_mod(1); run_steps(250, 1, 3, 3);
    // Window 4: random, then one step landing on the window-end cycle and
    // one landing on the first cycle of the next window.
    wait_mod(1); run_steps(150, 0, 1, 5);
    wait_mod(S - 4); drive_step(1); drive_step(1);
    // Window 5: 200 reverse steps, negative saturation on the narrow one.
    wait_mod(1); run_steps(200, -1, 1, 3);
    // Windows 6, 7: random.
    wait_mod(1); run_steps($urandom_range(0, 180), 0, 1, 4);
    wait_mod(1); run_steps($urandom_range(0, 180), 0, 1, 4);

    // Window 8: illegal double-bit change mid-window.
    wait_mod(1); run_steps(20, 0, 2, 2);
    check_eq("err_before", {30'd0, e1, e0}, 32'h0);
    @(negedge clk);
    begin
      int old;
      old = pos;
      pos = (pos + 2) % 4;
      {enc_a, enc_b} = gray(pos);
      model_apply(old, pos, cyc);
    end
    repeat (4) @(negedge clk);
    check_eq("err_set", {30'd0, e1, e0}, 32'h3);
    run_steps(20, 0, 2, 2);
    check_eq("err_sticky", {30'd0, e1, e0}, 32'h3);
    if (pos == 2) drive_step(1);   // keep the post-reset resync a legal step

    // Reset in the middle of the window-8 multiply.
    wait_mod(7);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("midrst_w16",   w0, 32'h0);
    check_eq("midrst_w8",    w1, 32'h0);
    check_eq("midrst_valid", {30'd0, v1, v0}, 32'h0);
    check_eq("midrst_err",   {30'd0, e1, e0}, 32'h0);
    last_w[0] = '0;
    last_w[1] = '0;
    model_clear();
    rst_n = 1'b1;
    // Synchronisers restart at 00 and then see the current encoder state.
    model_apply(0, pos, 0);

    wait_mod(1); run_steps(100, 1, 8, 8);
    wait_mod(1); run_steps(120, 0, 1, 5);
    do @(negedge clk); while (cyc < 2 * S - 1 + 18 + 4);
    check_eq("err_final", {30'd0, e1, e0}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
